prf_scheduler: RTL
==================

PRF_SCHEDULER -- requirements
Module: prf_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning the max cycles in RUN waiting for core_finish (used only with PRF_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-004 SHALL have port start  in  1  request a batch of PRF calls; sampled only in IDLE.
REQ-005 SHALL have port seed  in  256  PRF seed sigma; latched at start.
REQ-006 SHALL have port nonce0  in  8  first nonce; latched at start.
REQ-007 SHALL have port num_calls  in  3  number of PRF calls, 0..7; latched at start.
REQ-008 SHALL have port n_num  in  2  output length select, 1 = 1536 bits, 2 = 1024 bits; latched at start.
REQ-009 SHALL have port busy  out  1  high in every state except IDLE.
REQ-010 SHALL have port done  out  1  one-cycle pulse at batch end.
REQ-011 SHALL have port err  out  1  sticky error flag.
REQ-012 SHALL have port core_M  out  264  SHAKE-256 message, {seed_q, nonce_q}, with the seed in the MSBs.
REQ-013 SHALL have port core_n_num  out  2  latched n_num.
REQ-014 SHALL have port core_active  out  1  SHAKE-256 start level.
REQ-015 SHALL have port core_rst  out  1  active-high SHAKE-256 reset.
REQ-016 SHALL have port core_finish  in  1  SHAKE-256 finish level.
REQ-017 SHALL have port core_Z  in  1536  SHAKE-256 output.
REQ-018 SHALL have port out_data  out  1536  registered PRF output.
REQ-019 SHALL have port out_nonce  out  8  nonce that produced out_data.
REQ-020 SHALL have port out_valid  out  1  output handshake valid.
REQ-021 SHALL have port out_ready  in  1  consumer ready.

Function
REQ-022 SHALL implement the FSM states IDLE, CLR, RUN, HOLD and DONE.
REQ-023 In IDLE, start=1 with n_num in {1,2} and num_calls>0 SHALL latch the inputs, clear err, set calls_left=num_calls, and go to CLR next cycle.
REQ-024 In IDLE, start=1 with num_calls=0 and valid n_num SHALL go to DONE with no core activity.
REQ-025 In IDLE, start=1 with n_num in {0,3} SHALL set err=1 and stay IDLE; done SHALL NOT pulse.
REQ-026 CLR SHALL last exactly 1 cycle, drive core_rst=1 and core_active=0, then go to RUN.
REQ-027 RUN SHALL drive core_active=1 and core_rst=0 until core_finish=1 is sampled.
REQ-028 On sampling core_finish=1 in RUN, the block SHALL capture core_Z into out_data and nonce_q into out_nonce, then go to HOLD.
REQ-029 HOLD SHALL drive out_valid=1, core_active=0 and core_rst=1.
REQ-030 HOLD SHALL keep out_data and out_nonce stable until out_ready=1.
REQ-031 In HOLD with out_ready=1 and calls_left=1, the FSM SHALL go to DONE.
REQ-032 In HOLD with out_ready=1 and calls_left>1, the block SHALL decrement calls_left, increment nonce_q modulo 256 (0xFF wraps to 0x00), and go to CLR.
REQ-033 DONE SHALL pulse done=1 for 1 cycle, then go to IDLE.
REQ-034 start SHALL be ignored in every state other than IDLE.
REQ-035 core_M and core_n_num SHALL be constant from CLR through HOLD of each call.
REQ-036 Minimum latency per call SHALL be CLR(1) + RUN(core latency) + HOLD(≥1) cycles.
REQ-037 Back-to-back calls SHALL have no extra idle cycle between HOLD and CLR.
REQ-038 If out_ready=1 on the first HOLD cycle, the transfer SHALL complete in that cycle.

Reset
REQ-039 rst=0 at a clock edge SHALL force IDLE and clear busy, done, err, out_valid, core_active, out_data, out_nonce, calls_left and nonce_q.
REQ-040 While rst=0, the block SHALL drive core_rst=1.
REQ-041 Reset asserted mid-batch (any state) SHALL abort the batch; no done pulse and no further out_valid SHALL follow.
REQ-042 After reset, core_rst SHALL stay 1 while in IDLE.

Configuration
REQ-043 With macro PRF_TIMEOUT_EN defined, a cycle counter SHALL run in RUN, cleared on entry to RUN.
REQ-044 With PRF_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYC without core_finish, the block SHALL set err=1, go to IDLE, and pulse neither done nor out_valid.
REQ-045 Without PRF_TIMEOUT_EN, no counter SHALL exist and RUN SHALL wait indefinitely.

Verification
REQ-046 Scenario: start with seed=0x00..01, nonce0=0x00, num_calls=3, n_num=1, core model finishing 30 cycles after active, out_ready=1 -> 3 out_valid beats with out_nonce 0,1,2, core_M LSB byte matching, then done pulse 1 cycle after the last beat.
REQ-047 Scenario: nonce0=0xFE, num_calls=3 -> out_nonce sequence 0xFE, 0xFF, 0x00.
REQ-048 Scenario: out_ready held 0 for 10 cycles in HOLD -> out_valid held 10 cycles with out_data unchanged; core_active=0 throughout.
REQ-049 Scenario: start with n_num=3 -> err=1 next cycle, busy=0, no core_rst pulse edge; a following valid start clears err.
REQ-050 Scenario: num_calls=0 -> busy high 1 cycle, done pulse, core_active never 1.
REQ-051 Scenario: rst=0 during RUN of call 2 of 4 -> next cycle IDLE, all outputs 0 and core_rst=1; with PRF_TIMEOUT_EN and TIMEOUT_CYC=16, a core never finishing -> err=1 after 16 RUN cycles and no done pulse.

Source files
------------

// File: rtl/prf_scheduler.sv
// Sequences a batch of SHAKE-256 based PRF calls and hands each output to a consumer.
// Latency: CLR(1) + RUN(core latency) + HOLD(>=1) cycles per call, with no gap between calls.
// Backpressure: out_valid holds in HOLD with out_data/out_nonce stable until out_ready is high.
//
// Ports: clk/rst (sync, active-low); start/seed/nonce0/num_calls/n_num request a batch;
// busy/done/err report status; core_* drive and observe the SHAKE-256 core;
// out_data/out_nonce/out_valid/out_ready form the result handshake.
// Optional feature: define PRF_TIMEOUT_EN to abort RUN after TIMEOUT_CYC cycles without core_finish.
module prf_scheduler #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [255:0]  seed,
    input  logic [7:0]    nonce0,
    input  logic [2:0]    num_calls,
    input  logic [1:0]    n_num,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [263:0]  core_M,
    output logic [1:0]    core_n_num,
    output logic          core_active,
    output logic          core_rst,
    input  logic          core_finish,
    input  logic [1535:0] core_Z,
    output logic [1535:0] out_data,
    output logic [7:0]    out_nonce,
    output logic          out_valid,
    input  logic          out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [255:0]    seed_q, seed_d;
    logic [7:0]      nonce_q, nonce_d;
    logic [1:0]      n_num_q, n_num_d;
    logic [2:0]      calls_left_q, calls_left_d;
    logic            err_q, err_d;
    logic [1535:0]   out_data_q, out_data_d;
    logic [7:0]      out_nonce_q, out_nonce_d;

`ifdef PRF_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0]   tmo_q, tmo_d;
`endif

    logic nnum_ok;
    assign nnum_ok = (n_num == 2'd1) || (n_num == 2'd2);

    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        nonce_d      = nonce_q;
        n_num_d      = n_num_q;
        calls_left_d = calls_left_q;
        err_d        = err_q;
        out_data_d   = out_data_q;
        out_nonce_d  = out_nonce_q;
        core_active  = 1'b0;
        core_rst     = 1'b1;
        out_valid    = 1'b0;
        done         = 1'b0;
`ifdef PRF_TIMEOUT_EN
        // Counter only advances in RUN, so it is zero on every entry to RUN.
        tmo_d        = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (nnum_ok) begin
                        seed_d       = seed;
                        nonce_d      = nonce0;
                        n_num_d      = n_num;
                        calls_left_d = num_calls;
                        err_d        = 1'b0;
                        state_d      = (num_calls == 3'd0) ? S_DONE : S_CLR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLR: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                core_active = 1'b1;
                core_rst    = 1'b0;
`ifdef PRF_TIMEOUT_EN
                tmo_d       = tmo_q + 1'b1;
`endif
                if (core_finish) begin
                    out_data_d  = core_Z;
                    out_nonce_d = nonce_q;
                    state_d     = S_HOLD;
                end
`ifdef PRF_TIMEOUT_EN
                else if (tmo_q == CW'(TIMEOUT_CYC - 1)) begin
                    // tmo_q counts completed RUN cycles; this is the last allowed one.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (calls_left_q == 3'd1) begin
                        state_d = S_DONE;
                    end else begin
                        calls_left_d = calls_left_q - 3'd1;
                        nonce_d      = nonce_q + 8'd1;
                        state_d      = S_CLR;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Hold the core in reset for as long as our own reset is asserted,
        // even before the state register has been cleared.
        if (!rst) begin
            core_rst    = 1'b1;
            core_active = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            seed_q       <= '0;
            nonce_q      <= '0;
            n_num_q      <= '0;
            calls_left_q <= '0;
            err_q        <= 1'b0;
            out_data_q   <= '0;
            out_nonce_q  <= '0;
`ifdef PRF_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            nonce_q      <= nonce_d;
            n_num_q      <= n_num_d;
            calls_left_q <= calls_left_d;
            err_q        <= err_d;
            out_data_q   <= out_data_d;
            out_nonce_q  <= out_nonce_d;
`ifdef PRF_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;
    assign core_M     = {seed_q, nonce_q};
    assign core_n_num = n_num_q;
    assign out_data   = out_data_q;
    assign out_nonce  = out_nonce_q;

endmodule
